vga_timing_gen: RTL and testbench

Generates 640x480@60 VGA raster timing for the Game-of-Life display pipeline.
- Produces the pixel coordinates, sync pulses, active-video flag and blanking/frame strobes.
- Its outputs feed the board renderer and the simulation control FSM.
- Sits directly upstream of the renderer; clk doubles as pixel clock, and the optional pixel enable allows a faster system clock.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_timing_gen_wrap_counter.sv | 32 +++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, derived totals/sync windows and the
// coordinate width shared by the timing generator and its counters.
package vga_timing_pkg;

   localparam int COORD_W     = 10;
   localparam int COORD_LIMIT = 1 << COORD_W;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   function automatic int total4(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

   localparam int DEF_H_TOTAL    = total4(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int DEF_V_TOTAL    = total4(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
   localparam int DEF_HS_START   = DEF_H_DISPLAY + DEF_H_FRONT;
   localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC - 1;
   localparam int DEF_VS_START   = DEF_V_DISPLAY + DEF_V_FRONT;
   localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter that advances on inc and flags the cycle it rolls
// over; it comes out of reset at MAX so the first increment lands on 0.
module wrap_counter
   import vga_timing_pkg::*;
#(
   parameter int MAX = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   output logic [COORD_W-1:0] count,
   output logic               wrap
);

   localparam logic [COORD_W-1:0] LAST = COORD_W'(MAX);

   logic [COORD_W-1:0] r_count;

   assign wrap  = inc && (r_count == LAST);
   assign count = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= LAST;
      end else if (wrap) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + COORD_W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, syncs, active/blank flags and strobes,
// all registered so every output describes the same pixel.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY       = DEF_H_DISPLAY,
   parameter int H_FRONT         = DEF_H_FRONT,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BACK          = DEF_H_BACK,
   parameter int V_DISPLAY       = DEF_V_DISPLAY,
   parameter int V_FRONT         = DEF_V_FRONT,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int FRAME_CNT_W     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce,
   output logic [COORD_W-1:0]     hpos,
   output logic [COORD_W-1:0]     vpos,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   display_on,
   output logic                   vblank,
   output logic                   line_start,
   output logic                   frame_start,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam int H_TOTAL = total4(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = total4(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   generate
      if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_timing
         $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
      end
   endgenerate

   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
   localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
   localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
   localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic               SYNC_ON  = (SYNC_ACTIVE_LOW == 0) ? 1'b1 : 1'b0;

   logic [COORD_W-1:0] w_h_count;
   logic [COORD_W-1:0] w_v_count;
   logic [COORD_W-1:0] w_h_next;
   logic [COORD_W-1:0] w_v_next;
   logic               w_h_wrap;
   logic               w_v_inc;
   logic               w_v_wrap;

   logic                   r_hsync;
   logic                   r_vsync;
   logic                   r_display_on;
   logic                   r_vblank;
   logic                   r_line_start;
   logic                   r_frame_start;
   logic [FRAME_CNT_W-1:0] r_frame_count;

   assign w_v_inc = ce & w_h_wrap;

   wrap_counter #(.MAX(H_TOTAL - 1)) u_hcnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ce),
      .count (w_h_count),
      .wrap  (w_h_wrap)
   );

   wrap_counter #(.MAX(V_TOTAL - 1)) u_vcnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_v_inc),
      .count (w_v_count),
      .wrap  (w_v_wrap)
   );

   // Flags are decoded from the coordinates being entered so they line up
   // with the counter registers on the same edge.
   assign w_h_next = w_h_wrap ? '0 : (ce ? w_h_count + COORD_W'(1) : w_h_count);
   assign w_v_next = w_v_wrap ? '0 : (w_v_inc ? w_v_count + COORD_W'(1) : w_v_count);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hsync       <= ~SYNC_ON;
         r_vsync       <= ~SYNC_ON;
         r_display_on  <= 1'b0;
         r_vblank      <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '1;
      end else if (ce) begin
         r_hsync       <= (w_h_next >= HS_FIRST && w_h_next <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
         r_vsync       <= (w_v_next >= VS_FIRST && w_v_next <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
         r_display_on  <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
         r_vblank      <= (w_v_next >= V_VIS);
         r_line_start  <= (w_h_next == '0);
         r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
         if (w_v_wrap) begin
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
         end
      end
   end

   assign hpos        = w_h_count;
   assign vpos        = w_v_count;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign display_on  = r_display_on;
   assign vblank      = r_vblank;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a tiny-raster,
// active-high-sync instance so whole frames and counter wraps stay short.
module tb_vga_timing_gen;

   localparam int FCW = 8;

   // default instance geometry
   localparam int D_HD = 640, D_HF = 16, D_HS = 96, D_HB = 48;
   localparam int D_VD = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
   localparam int D_HT = D_HD + D_HF + D_HS + D_HB;
   localparam int D_VT = D_VD + D_VF + D_VS + D_VB;
   // small instance geometry
   localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
   localparam int S_VD = 6, S_VF = 1, S_VS = 2, S_VB = 3;
   localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

   typedef struct packed {
      logic [9:0]     hpos;
      logic [9:0]     vpos;
      logic           hsync;
      logic           vsync;
      logic           disp;
      logic           vblank;
      logic           ls;
      logic           fs;
      logic [FCW-1:0] fc;
   } out_t;

   typedef struct {
      bit ce;
      int h;
      int v;
      bit ls;
      bit fs;
      int fc;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ce = 1'b0;

   logic [9:0]     d_hpos, d_vpos, s_hpos, s_vpos;
   logic           d_hsync, d_vsync, d_disp, d_vblank, d_ls, d_fs;
   logic           s_hsync, s_vsync, s_disp, s_vblank, s_ls, s_fs;
   logic [FCW-1:0] d_fc, s_fc;

   always #5 clk = ~clk;

   vga_timing_gen u_dut (
      .clk(clk), .reset(reset), .ce(ce),
      .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync),
      .display_on(d_disp), .vblank(d_vblank), .line_start(d_ls),
      .frame_start(d_fs), .frame_count(d_fc)
   );

   vga_timing_gen #(
      .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
      .SYNC_ACTIVE_LOW(0), .FRAME_CNT_W(FCW)
   ) u_small (
      .clk(clk), .reset(reset), .ce(ce),
      .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
      .display_on(s_disp), .vblank(s_vblank), .line_start(s_ls),
      .frame_start(s_fs), .frame_count(s_fc)
   );

   int n_vec = 0;
   int n_bad = 0;
   out_t q0[$];
   out_t q1[$];
   int m0_h, m0_v, m0_fc, m1_h, m1_v, m1_fc;

   function automatic out_t predict(input int h, input int v, input int fc,
                                    input int hd, input int hf, input int hsw,
                                    input int vd, input int vf, input int vsw,
                                    input bit actlow);
      out_t o;
      bit hs_act;
      bit vs_act;
      hs_act   = (h >= hd + hf) && (h < hd + hf + hsw);
      vs_act   = (v >= vd + vf) && (v < vd + vf + vsw);
      o.hpos   = 10'(h);
      o.vpos   = 10'(v);
      o.hsync  = actlow ? ~hs_act : hs_act;
      o.vsync  = actlow ? ~vs_act : vs_act;
      o.disp   = (h < hd) && (v < vd);
      o.vblank = (v >= vd);
      o.ls     = (h == 0);
      o.fs     = (h == 0) && (v == 0);
      o.fc     = FCW'(fc);
      return o;
   endfunction

   function automatic out_t exp0();
      return predict(m0_h, m0_v, m0_fc, D_HD, D_HF, D_HS, D_VD, D_VF, D_VS, 1'b1);
   endfunction

   function automatic out_t exp1();
      return predict(m1_h, m1_v, m1_fc, S_HD, S_HF, S_HS, S_VD, S_VF, S_VS, 1'b0);
   endfunction

   function automatic out_t got0();
      out_t o;
      o = '{hpos:d_hpos, vpos:d_vpos, hsync:d_hsync, vsync:d_vsync, disp:d_disp,
            vblank:d_vblank, ls:d_ls, fs:d_fs, fc:d_fc};
      return o;
   endfunction

   function automatic out_t got1();
      out_t o;
      o = '{hpos:s_hpos, vpos:s_vpos, hsync:s_hsync, vsync:s_vsync, disp:s_disp,
            vblank:s_vblank, ls:s_ls, fs:s_fs, fc:s_fc};
      return o;
   endfunction

   function automatic string fmt(input out_t o);
      return $sformatf("h=%0d v=%0d hs=%b vs=%b de=%b vb=%b ls=%b fs=%b fc=%0d",
                       o.hpos, o.vpos, o.hsync, o.vsync, o.disp, o.vblank, o.ls, o.fs, o.fc);
   endfunction

   task automatic check(input string name, input out_t got, input out_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s: got {%s} required {%s}", name, fmt(got), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   task automatic adv(inout int h, inout int v, inout int fc, input int ht, input int vt);
      h = (h + 1) % ht;
      if (h == 0) begin
         v = (v + 1) % vt;
         if (v == 0) fc = (fc + 1) % (1 << FCW);
      end
   endtask

   task automatic model_step(input bit in_reset, input bit c);
      if (in_reset) begin
         m0_h = D_HT - 1; m0_v = D_VT - 1; m0_fc = (1 << FCW) - 1;
         m1_h = S_HT - 1; m1_v = S_VT - 1; m1_fc = (1 << FCW) - 1;
      end else if (c) begin
         adv(m0_h, m0_v, m0_fc, D_HT, D_VT);
         adv(m1_h, m1_v, m1_fc, S_HT, S_VT);
      end
   endtask

   // One clock: drive ce, queue the predicted pixel, compare after the edge.
   task automatic step(input bit c);
      @(negedge clk);
      ce = c;
      model_step(reset, c);
      q0.push_back(exp0());
      q1.push_back(exp1());
      @(posedge clk);
      #1;
      check("dflt_px", got0(), q0.pop_front());
      check("small_px", got1(), q1.pop_front());
   endtask

   vec_t tbl[5];

   task automatic run_table(input string tag);
      for (int i = 0; i < 5; i++) begin
         step(tbl[i].ce);
         check_int({tag, "_hpos"}, int'(d_hpos), tbl[i].h);
         check_int({tag, "_vpos"}, int'(d_vpos), tbl[i].v);
         check_int({tag, "_ls"}, int'(d_ls), int'(tbl[i].ls));
         check_int({tag, "_fs"}, int'(d_fs), int'(tbl[i].fs));
         check_int({tag, "_fc"}, int'(d_fc), tbl[i].fc);
      end
   endtask

   out_t rst_vec;
   int cnt_hs, cnt_de, cnt_vs, cnt_vb, cnt_fs, cnt_ls, cnt_wrap;
   logic [FCW-1:0] prev_fc;

   initial begin
      // ce pattern 1,0,0,1,1 from reset release: (0,0) held with strobes, then hpos 1, 2
      tbl[0] = '{ce:1'b1, h:0, v:0, ls:1'b1, fs:1'b1, fc:0};
      tbl[1] = '{ce:1'b0, h:0, v:0, ls:1'b1, fs:1'b1, fc:0};
      tbl[2] = '{ce:1'b0, h:0, v:0, ls:1'b1, fs:1'b1, fc:0};
      tbl[3] = '{ce:1'b1, h:1, v:0, ls:1'b0, fs:1'b0, fc:0};
      tbl[4] = '{ce:1'b1, h:2, v:0, ls:1'b0, fs:1'b0, fc:0};
      rst_vec = '{hpos:10'd799, vpos:10'd524, hsync:1'b1, vsync:1'b1, disp:1'b0,
                  vblank:1'b1, ls:1'b0, fs:1'b0, fc:8'hFF};

      #1 reset = 1'b1;
      model_step(1'b1, 1'b0);
      step(1'b1);
      step(1'b1);
      check("reset_const", got0(), rst_vec);
      @(negedge clk);
      ce = 1'b0;
      reset = 1'b0;
      run_table("first_px");

      // finish line 0: next pixel after hpos 799 is (0,1)
      for (int i = 0; i < D_HT - 2; i++) step(1'b1);
      check_int("line1_hpos", int'(d_hpos), 0);
      check_int("line1_vpos", int'(d_vpos), 1);
      check_int("line1_ls", int'(d_ls), 1);
      check_int("line1_fs", int'(d_fs), 0);

      cnt_hs = 0;
      cnt_de = 0;
      for (int i = 0; i < D_HT; i++) begin
         step(1'b1);
         if (d_hsync == 1'b0) cnt_hs++;
         if (d_disp == 1'b1) cnt_de++;
      end
      check_int("hsync_width", cnt_hs, D_HS);
      check_int("display_width", cnt_de, D_HD);

      for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0);

      for (int i = 0; i < 2 * D_HT && m0_h != 300; i++) step(1'b1);
      check_int("seek_h300", int'(d_hpos), 300);

      // asynchronous reset between edges, sampled before any clock edge
      #3;
      reset = 1'b1;
      model_step(1'b1, 1'b0);
      q0.push_back(exp0());
      q1.push_back(exp1());
      #1;
      check("async_rst_dflt", got0(), q0.pop_front());
      check("async_rst_small", got1(), q1.pop_front());
      check("async_rst_const", got0(), rst_vec);
      step(1'b1);
      @(negedge clk);
      ce = 1'b0;
      reset = 1'b0;
      run_table("after_rst");

      // 256 small-raster frames: every position sampled 256 times
      cnt_vs = 0; cnt_vb = 0; cnt_fs = 0; cnt_ls = 0; cnt_wrap = 0;
      prev_fc = s_fc;
      for (int i = 0; i < 256 * S_HT * S_VT; i++) begin
         step(1'b1);
         if (s_vsync == 1'b1) cnt_vs++;
         if (s_vblank == 1'b1) cnt_vb++;
         if (s_fs == 1'b1) cnt_fs++;
         if (s_ls == 1'b1) cnt_ls++;
         if (prev_fc == 8'hFF && s_fc == 8'h00) cnt_wrap++;
         prev_fc = s_fc;
      end
      check_int("vsync_cycles", cnt_vs, 256 * S_VS * S_HT);
      check_int("vblank_cycles", cnt_vb, 256 * (S_VT - S_VD) * S_HT);
      check_int("frame_pulses", cnt_fs, 256);
      check_int("line_pulses", cnt_ls, 256 * S_VT);
      check_int("fc_wraps", cnt_wrap, 1);
      check_int("fc_end", int'(s_fc), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
